// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, byte masks
// and the small decode helpers used at request acceptance.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_STORE,
        ST_RESP
    } state_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Illegal size or an address not aligned to the access size.
    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    is_bad = 1'b0;
            SZ_H:    is_bad = off[0];
            SZ_W:    is_bad = (off != 2'b00);
            default: is_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    size_mask = MASK_B;
            SZ_H:    size_mask = MASK_H;
            default: size_mask = MASK_W;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    store_data = {24'b0, wdata[7:0]};
            SZ_H:    store_data = {16'b0, wdata[15:0]};
            default: store_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: pulls a byte/half out of a memory word with zero or
// sign extension, and merges right-justified store data into a memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_merged
);

    logic [4:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_sh   = {i_off, 3'b000};
    assign w_byte = i_rdata[w_sh +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_ld_data = i_rdata;
        o_merged  = i_wdata;
        case (i_size)
            SZ_B: begin
                o_ld_data           = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merged            = i_rdata;
                o_merged[w_sh +: 8] = i_wdata[7:0];
            end
            SZ_H: begin
                o_ld_data = {{16{i_signed & w_half[15]}}, w_half};
                o_merged  = i_rdata;
                if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
                else          o_merged[15:0]  = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding access, sub-word stores at non-zero
// offsets become a read-modify-write of the whole word. All outputs registered.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_w_mask,
    output logic [3:0]  mem_r_mask,
    input  logic [31:0] mem_rdata
);

    state_e      r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_wdata;
    logic        r_resp_valid, r_resp_err;
    logic [31:0] r_resp_rdata;
    logic        r_mem_ce, r_mem_we, r_mem_rd;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic [3:0]  r_mem_w_mask, r_mem_r_mask;
    logic [31:0] w_ld_data, w_merged;

    lsu_lane_align u_align (
        .i_off     (r_addr[1:0]),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .i_rdata   (mem_rdata),
        .i_wdata   (r_wdata),
        .o_ld_data (w_ld_data),
        .o_merged  (w_merged)
    );

    // Gated by rst_n so the handshake stays closed while reset is held.
    assign req_ready  = rst_n && (r_state == ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_ce     = r_mem_ce;
    assign mem_we     = r_mem_we;
    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_w_mask = r_mem_w_mask;
    assign mem_r_mask = r_mem_r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_ce     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_w_mask <= '0;
            r_mem_r_mask <= '0;
        end else begin
            // Memory strobes and the response pulse last one state unless re-armed.
            r_resp_valid <= 1'b0;
            r_mem_ce     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_w_mask <= '0;
            r_mem_r_mask <= '0;
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_addr   <= req_addr;
                    r_size   <= req_size;
                    r_signed <= req_signed;
                    r_wdata  <= req_wdata;
                    if (is_bad(req_size, req_addr[1:0])) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else begin
                        r_mem_ce   <= 1'b1;
                        r_mem_addr <= {req_addr[31:2], 2'b00};
                        if (!req_we) begin
                            r_state      <= ST_LOAD;
                            r_mem_rd     <= 1'b1;
                            r_mem_r_mask <= MASK_W;
                        end else if (req_size == SZ_W || req_addr[1:0] == 2'b00) begin
                            r_state      <= ST_STORE;
                            r_mem_we     <= 1'b1;
                            r_mem_w_mask <= size_mask(req_size);
                            r_mem_wdata  <= store_data(req_size, req_wdata);
                        end else begin
                            r_state      <= ST_RMW_RD;
                            r_mem_rd     <= 1'b1;
                            r_mem_r_mask <= MASK_W;
                        end
                    end
                end
                ST_LOAD: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= w_ld_data;
                end
                ST_RMW_RD: begin
                    // Merged word is held in the write-data register for RMW_WR.
                    r_state      <= ST_RMW_WR;
                    r_mem_ce     <= 1'b1;
                    r_mem_we     <= 1'b1;
                    r_mem_w_mask <= MASK_W;
                    r_mem_addr   <= {r_addr[31:2], 2'b00};
                    r_mem_wdata  <= w_merged;
                end
                ST_STORE, ST_RMW_WR: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
